// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam int              OPC_W     = 4;
  localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;
  localparam logic [15:0]     INSTR_NOP = 16'h0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is stalled.
module fetch_hold_buf #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_plus2_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_plus2_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_plus2_q;

  // Clear (redirect) beats load; the payload is left stale since valid gates it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus2_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus2_q <= pc_plus2_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and fills IF/ID.
// Handles memory wait states, hazard stalls, redirects from ID and HLT.
module fetch_stage #(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HALT_OPC = cpu_pkg::HALT_OPC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               br_taken_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rdy_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               ifid_valid_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [ADDR_W-1:0]  ifid_pc_plus2_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               halted_o
);

  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, drain_addr_q, pc_plus2, br_addr;
  logic               ifid_valid_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [ADDR_W-1:0]  ifid_pc_plus2_q;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc_plus2;
  logic               fetch_done, is_halt;

  assign pc_plus2   = pc_q + ADDR_W'(2);
  assign br_addr    = br_target_i & ~ADDR_W'(1);
  assign fetch_done = (state_q == FETCH) && !hold_valid && imem_rdy_i;
  assign is_halt    = (imem_data_i[INSTR_W-1 -: OPC_W] == HALT_OPC);

  fetch_hold_buf #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) u_hold (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (fetch_done && stall_i),
    .unload_i   (hold_valid && !stall_i),
    .clear_i    (br_taken_i),
    .instr_i    (imem_data_i),
    .pc_plus2_i (pc_plus2),
    .valid_o    (hold_valid),
    .instr_o    (hold_instr),
    .pc_plus2_o (hold_pc_plus2)
  );

  // A redirect while a request is still waiting must let that request finish at its old address.
  always_comb begin
    state_d     = state_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        imem_req_o = !hold_valid;
        if (br_taken_i) begin
          if (!hold_valid && !imem_rdy_i) state_d = DRAIN;
        end else if (fetch_done && is_halt) begin
          state_d = HALTED;
        end
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        if (imem_rdy_i) state_d = FETCH;
      end
      HALTED: if (br_taken_i) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      drain_addr_q    <= '0;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= INSTR_NOP;
      ifid_pc_plus2_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && br_taken_i && !hold_valid && !imem_rdy_i)
        drain_addr_q <= pc_q;
      if (br_taken_i) begin
        pc_q         <= br_addr;
        ifid_valid_q <= 1'b0;
      end else begin
        // HLT stays at its own address so a later redirect is the only way out.
        if (fetch_done && !is_halt) pc_q <= pc_plus2;
        if (!stall_i) begin
          if (fetch_done) begin
            ifid_valid_q    <= 1'b1;
            ifid_instr_q    <= imem_data_i;
            ifid_pc_plus2_q <= pc_plus2;
          end else if (hold_valid) begin
            ifid_valid_q    <= 1'b1;
            ifid_instr_q    <= hold_instr;
            ifid_pc_plus2_q <= hold_pc_plus2;
          end else begin
            ifid_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  assign ifid_valid_o    = ifid_valid_q;
  assign ifid_instr_o    = ifid_instr_q;
  assign ifid_pc_plus2_o = ifid_pc_plus2_q;
  assign pc_o            = pc_q;
  assign halted_o        = (state_q == HALTED);

endmodule
